// File: rtl/svm_mem_pkg.sv
// Shared definitions for the SVM support/alpha SRAM read path.
// Holds the bank geometry, the row payload carried from the SRAM capture
// stage to the downstream kernel, and the read-sequencer state encoding.
package svm_mem_pkg;

  localparam int NBITS       = 9;
  localparam int VSUP_WIDTH  = 120;
  localparam int ASUP_WIDTH  = 155;
  localparam int NUM_SV      = 214;
  localparam int NUM_V_ALPHA = 120;
  localparam int NUM_A_ALPHA = 155;

  function automatic int ceilLog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int ADDR_W = ceilLog2(NUM_SV);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } svmState_e;

  typedef struct packed {
    logic        [ADDR_W-1:0]           index;
    logic        [NBITS*VSUP_WIDTH-1:0] vSupport;
    logic signed [NBITS-1:0]            vAlpha;
    logic        [NBITS*ASUP_WIDTH-1:0] aSupport;
    logic signed [NBITS-1:0]            aAlpha;
  } rowPayload_t;

  localparam int ROW_W = $bits(rowPayload_t);

endpackage

// File: rtl/svm_row_fifo2.sv
// Two-entry first-word-fall-through FIFO.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (control only)
//   flush      - synchronous empty, same effect as rst on the pointers
//   push, din  - write one entry (ignored when full)
//   pop        - consume the head entry (ignored when empty)
//   dout       - head entry, valid whenever empty is low
//   empty      - no entries held
//   count      - number of entries held (0..2)
module svm_row_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot [2];
  logic             wrPtr;
  logic             rdPtr;
  logic [1:0]       cnt;
  logic             doPush;
  logic             doPop;

  assign doPush = push && (cnt != 2'd2);
  assign doPop  = pop && (cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt   <= 2'd0;
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
    end else begin
      if (doPush) wrPtr <= ~wrPtr;
      if (doPop)  rdPtr <= ~rdPtr;
      case ({doPush, doPop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (doPush) slot[wrPtr] <= din;
  end

  assign dout  = slot[rdPtr];
  assign empty = (cnt == 2'd0);
  assign count = cnt;

endmodule

// File: rtl/svm_support_reader.sv
// Read-side sequencer for the SVM support/alpha SRAM bank.
// On start it walks addresses 0..NUM_SV-1, absorbs the one-cycle SRAM read
// latency through a 2-entry FWFT FIFO and streams each row with its gated
// video/audio alpha over a valid/ready interface at up to one row per cycle.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start, abort        - begin a pass (IDLE only) / flush to IDLE
//   busy, done          - pass in progress / one-cycle end-of-pass pulse
//   mem_addr, mem_we    - SRAM address and WEB (held at 1, read only)
//   mem_*               - SRAM Q: video/audio support rows and alphas
//   out_valid/out_ready - downstream handshake
//   out_index, out_last - row index and last-row flag
//   out_v_*, out_a_*    - support rows, gated alphas and alpha-valid flags
module svm_support_reader
  import svm_mem_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_we,
  input  logic [NBITS*VSUP_WIDTH-1:0] mem_v_support,
  input  logic [NBITS-1:0]            mem_v_alpha,
  input  logic [NBITS*ASUP_WIDTH-1:0] mem_a_support,
  input  logic [NBITS-1:0]            mem_a_alpha,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ADDR_W-1:0]           out_index,
  output logic                        out_last,
  output logic [NBITS*VSUP_WIDTH-1:0] out_v_support,
  output logic [NBITS-1:0]            out_v_alpha,
  output logic                        out_v_alpha_valid,
  output logic [NBITS*ASUP_WIDTH-1:0] out_a_support,
  output logic [NBITS-1:0]            out_a_alpha,
  output logic                        out_a_alpha_valid
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_SV - 1);
  localparam logic [ADDR_W-1:0] V_ALPHA_N = ADDR_W'(NUM_V_ALPHA);
  localparam logic [ADDR_W-1:0] A_ALPHA_N = ADDR_W'(NUM_A_ALPHA);

  svmState_e         state;
  logic [ADDR_W-1:0] rdIdx;
  logic              vld_p1;
  logic [ADDR_W-1:0] tagIdx_p1;
  logic              pop;
  logic              issue;
  logic [2:0]        credit;
  logic [1:0]        fifoCount;
  logic              fifoEmpty;
  rowPayload_t       pushRow;
  rowPayload_t       headRow;

  // Rows already owed to the FIFO after this cycle's pop; issuing only while
  // this is below 2 keeps the 2-entry FIFO from ever overflowing.
  assign pop    = out_valid && out_ready;
  assign credit = {1'b0, fifoCount} + {2'b00, vld_p1} - {2'b00, pop};
  assign issue  = (state == RUN) && (credit < 3'd2);

  // Stage p0: issue the read address and run the pass FSM.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state  <= IDLE;
      rdIdx  <= '0;
      vld_p1 <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      vld_p1 <= issue;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (issue) begin
            if (rdIdx == LAST_IDX) begin
              rdIdx <= '0;
              state <= DRAIN;
            end else begin
              rdIdx <= rdIdx + 1'b1;
            end
          end
        end
        DRAIN: begin
          // credit == 0: nothing in flight and the FIFO empties this cycle.
          if (credit == 3'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tagIdx_p1 <= rdIdx;
  end

  assign mem_addr = rdIdx;
  assign mem_we   = 1'b1;

  // Stage p1: SRAM Q is valid; capture it with its tag into the FIFO.
  assign pushRow.index    = tagIdx_p1;
  assign pushRow.vSupport = mem_v_support;
  assign pushRow.vAlpha   = mem_v_alpha;
  assign pushRow.aSupport = mem_a_support;
  assign pushRow.aAlpha   = mem_a_alpha;

  svm_row_fifo2 #(
    .WIDTH(ROW_W)
  ) uFifo (
    .clk  (clk),
    .rst  (rst),
    .flush(abort),
    .push (vld_p1),
    .din  (pushRow),
    .pop  (pop),
    .dout (headRow),
    .empty(fifoEmpty),
    .count(fifoCount)
  );

  // Stage p2: FIFO head drives the stream; payload reads as 0 while idle.
  assign out_valid         = !fifoEmpty;
  assign out_index         = out_valid ? headRow.index : '0;
  assign out_last          = out_valid && (headRow.index == LAST_IDX);
  assign out_v_support     = out_valid ? headRow.vSupport : '0;
  assign out_a_support     = out_valid ? headRow.aSupport : '0;
  assign out_v_alpha_valid = out_valid && (headRow.index < V_ALPHA_N);
  assign out_a_alpha_valid = out_valid && (headRow.index < A_ALPHA_N);
  assign out_v_alpha       = out_v_alpha_valid ? headRow.vAlpha : '0;
  assign out_a_alpha       = out_a_alpha_valid ? headRow.aAlpha : '0;

endmodule

// File: tb/tb_svm_support_reader.sv
// Bench for svm_support_reader: SRAM model with one-cycle read latency,
// an index scoreboard filled at start and drained by accepted rows, a
// hand-written alpha-gating table and multi-cycle corner-case sequences.
module tb_svm_support_reader;
  import svm_mem_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        start = 1'b0;
  logic                        abort = 1'b0;
  logic                        out_ready = 1'b1;
  logic                        busy, done, mem_we, out_valid, out_last;
  logic                        out_v_alpha_valid, out_a_alpha_valid;
  logic [ADDR_W-1:0]           mem_addr, out_index;
  logic [NBITS*VSUP_WIDTH-1:0] mem_v_support, out_v_support;
  logic [NBITS*ASUP_WIDTH-1:0] mem_a_support, out_a_support;
  logic [NBITS-1:0]            mem_v_alpha, mem_a_alpha, out_v_alpha, out_a_alpha;

  svm_support_reader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_v_support(mem_v_support), .mem_v_alpha(mem_v_alpha),
    .mem_a_support(mem_a_support), .mem_a_alpha(mem_a_alpha),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index), .out_last(out_last),
    .out_v_support(out_v_support), .out_v_alpha(out_v_alpha), .out_v_alpha_valid(out_v_alpha_valid),
    .out_a_support(out_a_support), .out_a_alpha(out_a_alpha), .out_a_alpha_valid(out_a_alpha_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [NBITS*VSUP_WIDTH-1:0] rowV(input int i);
    logic [NBITS-1:0] c;
    c = NBITS'(i % 256);
    return {VSUP_WIDTH{c}};
  endfunction

  function automatic logic [NBITS*ASUP_WIDTH-1:0] rowA(input int i);
    logic [NBITS-1:0] c;
    c = NBITS'(i % 256);
    return {ASUP_WIDTH{c}};
  endfunction

  function automatic logic [NBITS-1:0] vaOf(input int i);
    return NBITS'(i * 5 + 3);
  endfunction

  function automatic logic [NBITS-1:0] aaOf(input int i);
    return NBITS'(511 - i * 3);
  endfunction

  // SRAM: Q reflects the address sampled at the previous edge.
  always @(posedge clk) begin
    mem_v_support <= rowV(int'(mem_addr));
    mem_a_support <= rowA(int'(mem_addr));
    mem_v_alpha   <= vaOf(int'(mem_addr));
    mem_a_alpha   <= aaOf(int'(mem_addr));
  end

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int readyMode = 0;
  int expQ[$];
  int startCyc = 0, firstValidRel = -1, lastRel = -1, doneRel = -1, doneCount = 0;
  int weErrors = 0;
  bit busyAtDone = 1'b0;
  bit capVV[NUM_SV], capAV[NUM_SV], capLast[NUM_SV], capVAz[NUM_SV], capAAz[NUM_SV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 99) < 30);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: scoreboard pop, hold-while-stalled checks, timing capture.
  initial begin
    bit                          prevStall;
    logic [ADDR_W-1:0]           prevIdx;
    logic [NBITS*VSUP_WIDTH-1:0] prevV;
    logic [NBITS*ASUP_WIDTH-1:0] prevA;
    int                          e;
    prevStall = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_we !== 1'b1) weErrors++;
      if (out_valid === 1'b1 && firstValidRel < 0) firstValidRel = cyc - startCyc;
      if (done === 1'b1) begin
        doneCount++;
        doneRel = cyc - startCyc;
        busyAtDone = busy;
      end
      if (prevStall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_index", 64'(out_index), 64'(prevIdx));
        chk("hold_data", 64'(out_v_support == prevV && out_a_support == prevA), 64'd1);
      end
      prevStall = (out_valid === 1'b1) && (out_ready === 1'b0) && (rst === 1'b0);
      prevIdx = out_index;
      prevV = out_v_support;
      prevA = out_a_support;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (expQ.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_row: got index %0d, expected no row", out_index);
        end else begin
          e = expQ.pop_front();
          chk("row_index", 64'(out_index), 64'(e));
          chk("row_last", 64'(out_last), 64'(e == NUM_SV - 1));
          chk("row_v_support", 64'(out_v_support == rowV(e)), 64'd1);
          chk("row_a_support", 64'(out_a_support == rowA(e)), 64'd1);
          chk("row_v_alpha_valid", 64'(out_v_alpha_valid), 64'(e < NUM_V_ALPHA));
          chk("row_a_alpha_valid", 64'(out_a_alpha_valid), 64'(e < NUM_A_ALPHA));
          chk("row_v_alpha", 64'(out_v_alpha), 64'((e < NUM_V_ALPHA) ? vaOf(e) : '0));
          chk("row_a_alpha", 64'(out_a_alpha), 64'((e < NUM_A_ALPHA) ? aaOf(e) : '0));
          if (out_last === 1'b1) lastRel = cyc - startCyc;
          if (int'(out_index) < NUM_SV) begin
            capVV[out_index]   = out_v_alpha_valid;
            capAV[out_index]   = out_a_alpha_valid;
            capLast[out_index] = out_last;
            capVAz[out_index]  = (out_v_alpha == '0);
            capAAz[out_index]  = (out_a_alpha == '0);
          end
        end
      end
    end
  end

  task automatic startPass();
    @(posedge clk);
    #1;
    expQ.delete();
    for (int i = 0; i < NUM_SV; i++) expQ.push_back(i);
    firstValidRel = -1;
    lastRel = -1;
    doneRel = -1;
    doneCount = 0;
    startCyc = cyc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic waitRow(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && int'(out_index) == idx) ok = 1'b1;
    end
  endtask

  typedef struct {
    int idx;
    bit vv;
    bit av;
    bit last;
    bit vaZero;
    bit aaZero;
  } gateVec_t;

  initial begin
    gateVec_t gv[6];
    bit       ok;

    gv[0] = '{0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    gv[1] = '{119, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    gv[2] = '{120, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    gv[3] = '{154, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    gv[4] = '{155, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    gv[5] = '{213, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd1);
    chk("rst_out_index", 64'(out_index), 64'd0);
    chk("rst_out_data_zero", 64'(out_v_support == '0 && out_a_support == '0 && out_v_alpha == '0), 64'd1);
    rst = 1'b0;

    // Full throughput pass
    readyMode = 0;
    startPass();
    waitDone(400, ok);
    @(posedge clk);
    #1;
    chk("full_done_seen", 64'(ok), 64'd1);
    chk("full_first_valid_cycle", 64'(firstValidRel), 64'd3);
    chk("full_last_row_cycle", 64'(lastRel), 64'd216);
    chk("full_done_cycle", 64'(doneRel), 64'd217);
    chk("full_busy_in_done_cycle", 64'(busyAtDone), 64'd0);
    chk("full_rows_left", 64'(expQ.size()), 64'd0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("gate_vvalid_%0d", gv[k].idx), 64'(capVV[gv[k].idx]), 64'(gv[k].vv));
      chk($sformatf("gate_avalid_%0d", gv[k].idx), 64'(capAV[gv[k].idx]), 64'(gv[k].av));
      chk($sformatf("gate_last_%0d", gv[k].idx), 64'(capLast[gv[k].idx]), 64'(gv[k].last));
      chk($sformatf("gate_vzero_%0d", gv[k].idx), 64'(capVAz[gv[k].idx]), 64'(gv[k].vaZero));
      chk($sformatf("gate_azero_%0d", gv[k].idx), 64'(capAAz[gv[k].idx]), 64'(gv[k].aaZero));
    end

    // Random backpressure
    readyMode = 1;
    startPass();
    waitDone(3000, ok);
    @(posedge clk);
    #1;
    chk("rand_done_seen", 64'(ok), 64'd1);
    chk("rand_rows_left", 64'(expQ.size()), 64'd0);
    chk("rand_done_count", 64'(doneCount), 64'd1);

    // Long stall after first valid
    readyMode = 2;
    startPass();
    waitRow(0, 20, ok);
    chk("stall_first_valid", 64'(ok), 64'd1);
    repeat (50) @(negedge clk);
    chk("stall_rd_idx", 64'(mem_addr), 64'd2);
    chk("stall_valid_held", 64'(out_valid), 64'd1);
    chk("stall_row0_held", 64'(out_index), 64'd0);
    readyMode = 0;
    waitDone(400, ok);
    @(posedge clk);
    #1;
    chk("stall_done_seen", 64'(ok), 64'd1);
    chk("stall_rows_left", 64'(expQ.size()), 64'd0);

    // Abort at index 100
    readyMode = 0;
    startPass();
    waitRow(100, 300, ok);
    chk("abort_reached_100", 64'(ok), 64'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    expQ.delete();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_mem_addr", 64'(mem_addr), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(doneCount), 64'd0);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_with_abort_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk("start_with_abort_mem_addr", 64'(mem_addr), 64'd0);
    chk("start_with_abort_idle", 64'(busy), 64'd0);
    startPass();
    waitDone(400, ok);
    @(posedge clk);
    #1;
    chk("restart_done_seen", 64'(ok), 64'd1);
    chk("restart_first_valid_cycle", 64'(firstValidRel), 64'd3);
    chk("restart_rows_left", 64'(expQ.size()), 64'd0);

    // Reset during DRAIN
    startPass();
    waitRow(212, 300, ok);
    chk("drain_reached_212", 64'(ok), 64'd1);
    chk("drain_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    chk("drain_rst_busy", 64'(busy), 64'd0);
    chk("drain_rst_done", 64'(done), 64'd0);
    chk("drain_rst_out_valid", 64'(out_valid), 64'd0);
    chk("drain_rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("drain_rst_out_index", 64'(out_index), 64'd0);
    chk("drain_rst_out_last", 64'(out_last), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("drain_rst_no_done", 64'(doneCount), 64'd0);

    chk("mem_we_never_low", 64'(weErrors), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
